// File: rtl/logic_op_sched_if.sv
// Request/response bundle for logic_op_sched. It carries N_REQ packed request lanes,
// one response channel and the busy flag.
interface logic_op_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ*3-1:0]  req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic [IW-1:0]       rsp_id;
  logic                rsp_err;
  logic                busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/logic_op_sched.sv
// Round-robin scheduler feeding a two-stage bitwise-logic pipeline.
// S1 holds the granted operands and S2 holds the registered result.
module logic_op_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_op_sched_if.slave  bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
  } s1_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  function automatic rsp_t eval_op(input s1_t s);
    rsp_t r;
    r.id   = s.id;
    r.err  = 1'b0;
    r.data = '0;
    case (op_e'(s.op))
      OP_AND:  r.data = s.a & s.b;
      OP_NAND: r.data = ~(s.a & s.b);
      OP_OR:   r.data = s.a | s.b;
      OP_NOR:  r.data = ~(s.a | s.b);
      OP_XOR:  r.data = s.a ^ s.b;
      OP_XNOR: r.data = ~(s.a ^ s.b);
      default: r.err  = 1'b1;
    endcase
    return r;
  endfunction

  logic          s1_valid_q, s1_valid_d;
  s1_t           s1_q, s1_d;
  logic          rsp_valid_q, rsp_valid_d;
  rsp_t          rsp_q, rsp_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic             adv1, adv2;
  logic             gnt_found;
  logic [IW-1:0]    gnt_idx;
  logic [CW-1:0]    cand;
  logic [N_REQ-1:0] grant;

  assign adv2 = !rsp_valid_q || bus.rsp_ready;
  assign adv1 = !s1_valid_q || adv2;

  // The search starts at rr_ptr and wraps. The grant is held off during reset, so req_ready is 0 then.
  // NOTE: every always_comb target gets a default before any branch, so no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!gnt_found && adv1 && rst_n && bus.req_valid[cand[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
    grant = '0;
    if (gnt_found) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv1) begin
      s1_valid_d = gnt_found;
      if (gnt_found) begin
        s1_d.id = gnt_idx;
        s1_d.a  = bus.req_a[int'(gnt_idx)*DW +: DW];
        s1_d.b  = bus.req_b[int'(gnt_idx)*DW +: DW];
        s1_d.op = bus.req_op[int'(gnt_idx)*3 +: 3];
      end
    end
  end

  // The result is only reloaded behind a valid S1 entry. An empty S2 keeps its last payload.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (adv2) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) rsp_d = eval_op(s1_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.busy      = s1_valid_q | rsp_valid_q;
endmodule

// File: tb/tb_logic_op_sched.sv
// Self-checking bench for logic_op_sched: directed scenarios plus random traffic.
// All traffic is checked against an in-order flight-queue reference model.
module tb_logic_op_sched;
  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int PW    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_op_sched_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  logic_op_sched #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Each op in flight carries its age in edges. The oldest op is visible once it is 2 edges old.
  typedef struct {
    int            age;
    logic [DW-1:0] data;
    logic [PW-1:0] id;
    logic          err;
  } ent_t;

  ent_t q[$];
  int   m_ptr;
  int   n_tests, n_fail;

  logic [N_REQ-1:0] obs_ready;
  logic             obs_rv, obs_err, obs_busy;
  logic [DW-1:0]    obs_data;
  logic [PW-1:0]    obs_id;

  logic [N_REQ-1:0]    vv;
  logic [N_REQ*DW-1:0] va, vb;
  logic [N_REQ*3-1:0]  vop;
  logic [DW-1:0]       snap_data;
  logic [PW-1:0]       snap_id;
  logic [DW-1:0]       sweep_tab [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output logic [DW-1:0] r, output logic e);
    e = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = ~(a & b);
      3'd2: r = a | b;
      3'd3: r = ~(a | b);
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // One cycle: drive at negedge, compare mid-cycle, advance the model across the posedge.
  task automatic step(input logic [N_REQ-1:0] v, input logic [N_REQ*DW-1:0] a,
                      input logic [N_REQ*DW-1:0] b, input logic [N_REQ*3-1:0] op, input logic rr);
    logic             exp_rv, can_acc;
    logic [N_REQ-1:0] exp_gnt;
    int               g;
    ent_t             e;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.rsp_ready = rr;
    #1;
    exp_rv  = (q.size() > 0) && (q[0].age >= 2);
    can_acc = (q.size() < 2) || (exp_rv && rr);
    g = -1;
    if (can_acc)
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && v[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    obs_ready = bus.req_ready;
    obs_rv    = bus.rsp_valid;
    obs_data  = bus.rsp_data;
    obs_id    = bus.rsp_id;
    obs_err   = bus.rsp_err;
    obs_busy  = bus.busy;
    check("req_ready", 32'(obs_ready), 32'(exp_gnt));
    check("rsp_valid", 32'(obs_rv), 32'(exp_rv));
    check("busy", 32'(obs_busy), 32'(q.size() > 0));
    if (exp_rv) begin
      check("rsp_data", 32'(obs_data), 32'(q[0].data));
      check("rsp_id", 32'(obs_id), 32'(q[0].id));
      check("rsp_err", 32'(obs_err), 32'(q[0].err));
    end
    @(posedge clk);
    if (exp_rv && rr) void'(q.pop_front());
    foreach (q[j]) q[j].age++;
    if (g >= 0) begin
      ref_op(op[g*3 +: 3], a[g*DW +: DW], b[g*DW +: DW], e.data, e.err);
      e.id  = g[PW-1:0];
      e.age = 1;
      q.push_back(e);
      m_ptr = (g + 1) % N_REQ;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ptr   = 0;
    sweep_tab = '{8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h00, 8'h00};

    // While in reset, valid requests on every lane must not be granted.
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    #7;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness with all lanes valid. The grant order starts at requester 0.
    for (int k = 0; k < 10; k++) begin
      step((k < 8) ? 4'hF : 4'h0, 32'h11223344, 32'h0F0F0F0F, 12'o4321, 1'b1);
      if (k < 8) check("fair_gnt", 32'(obs_ready), 32'(1 << (k % 4)));
      if (k >= 2) check("fair_id", 32'(obs_id), 32'((k - 2) % 4));
    end

    // A single op is issued from requester 2 for one cycle.
    va = '0; vb = '0; vop = '0;
    va[2*DW +: DW] = 8'hF0;
    vb[2*DW +: DW] = 8'h3C;
    vop[2*3 +: 3]  = 3'd4;
    step(4'b0100, va, vb, vop, 1'b1);
    check("single_ready", 32'(obs_ready), 32'b0100);
    step('0, '0, '0, '0, 1'b1);
    step('0, '0, '0, '0, 1'b1);
    check("single_valid", 32'(obs_rv), 32'd1);
    check("single_data", 32'(obs_data), 32'hCC);
    check("single_id", 32'(obs_id), 32'd2);
    check("single_err", 32'(obs_err), 32'd0);

    // rr_ptr now points at 3. With only lanes 1 and 3 valid, the grants are 3 then 1.
    va = 32'h5A5A5A5A; vb = 32'h3C3C3C3C; vop = 12'o2222;
    step(4'b1010, va, vb, vop, 1'b1);
    check("wrap_first", 32'(obs_ready), 32'b1000);
    step(4'b1010, va, vb, vop, 1'b1);
    check("wrap_second", 32'(obs_ready), 32'b0010);
    idle(2);

    // Opcode sweep from requester 0, one result per cycle.
    for (int k = 0; k < 10; k++) begin
      va = 32'h000000A5; vb = 32'h0000000F; vop = '0;
      vop[2:0] = k[2:0];
      step((k < 8) ? 4'b0001 : 4'b0000, va, vb, vop, 1'b1);
      if (k >= 2) begin
        check("sweep_valid", 32'(obs_rv), 32'd1);
        check("sweep_data", 32'(obs_data), 32'(sweep_tab[k-2]));
        check("sweep_err", 32'(obs_err), 32'((k - 2) >= 6));
      end
    end

    // Backpressure: both stages fill, then grants stop and the outputs hold.
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 32'hDEADBEEF, 32'h12345678, 12'o5410, 1'b0);
      if (k >= 2) check("bp_ready", 32'(obs_ready), 32'd0);
      if (k == 2) begin
        snap_data = obs_data;
        snap_id   = obs_id;
      end
      if (k > 2) begin
        check("bp_hold_data", 32'(obs_data), 32'(snap_data));
        check("bp_hold_id", 32'(obs_id), 32'(snap_id));
      end
    end
    idle(4);
    check("bp_drained", 32'(obs_busy), 32'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      vv  = 4'($urandom);
      va  = $urandom;
      vb  = $urandom;
      vop = 12'($urandom);
      step(vv, va, vb, vop, $urandom_range(0, 9) < 7);
    end
    idle(4);

    // Reset with both stages valid is asserted mid-cycle.
    for (int k = 0; k < 3; k++) step(4'hF, 32'hCAFEF00D, 32'h0000FFFF, 12'o1234, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    q.delete();
    m_ptr = 0;
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    step(4'hF, 32'h01020304, 32'hFFFFFFFF, 12'o0123, 1'b1);
    check("post_rst_gnt", 32'(obs_ready), 32'b0001);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
